// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if -- request/response bus between an initiator (master)
// and the data memory responder (slave). Widths follow DWIDTH.
interface data_mem_responder_if #(
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [DWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              resp_valid;
    logic              resp_ready;
    logic [DWIDTH-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder -- single-port data memory with a valid/ready request
// channel, a programmable fixed response latency and byte/half/word accesses
// with sign or zero extension on loads.
// Optional feature: define DATA_MEM_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses and the reserved size with resp_err=1 (no write, rdata 0).
// Without it, resp_err stays 0 and misaligned low address bits are ignored.
module data_mem_responder #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input logic                  clk,
    input logic                  reset,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [DWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              err_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DWIDTH-1:0] rdata_q;
    logic              resp_err_q;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              accept;
    logic              req_err;
    logic              access_edge;
    logic              mem_we;
    logic [AW-1:0]     idx;
    logic [1:0]        lane;
    logic [4:0]        shamt;
    logic [DWIDTH-1:0] cur_word;
    logic [DWIDTH-1:0] lane_data;
    logic [DWIDTH-1:0] load_data;
    logic [DWIDTH-1:0] wr_mask;
    logic [DWIDTH-1:0] wr_data;
    logic [DWIDTH-1:0] new_word;
    logic              unused_addr;

    assign accept = bus.req_valid && req_ready_q;

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    assign req_err = (bus.req_size == 2'b11)
                  || (bus.req_size == 2'b01 && bus.req_addr[0])
                  || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    // The memory is touched only on the edge that moves WAIT -> RESP.
    assign access_edge = (state == WAIT) && (cnt == 4'd0);
    assign mem_we      = access_edge && we_q && !err_q && !reset;

    assign idx         = addr_q[AW+1:2];
    assign lane        = addr_q[1:0];
    assign cur_word    = mem[idx];
    assign unused_addr = ^addr_q[DWIDTH-1:AW+2];

    // Lane steering for both directions: load extraction/extension and store merge mask.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        shamt     = 5'd0;
        lane_data = cur_word;
        load_data = cur_word;
        wr_mask   = '1;
        wr_data   = wdata_q;
        case (size_q)
            2'b00: begin
                shamt     = {lane, 3'b000};
                lane_data = cur_word >> shamt;
                load_data = {{(DWIDTH-8){~uns_q & lane_data[7]}}, lane_data[7:0]};
                wr_mask   = DWIDTH'(8'hFF) << shamt;
                wr_data   = DWIDTH'(wdata_q[7:0]) << shamt;
            end
            2'b01: begin
                shamt     = {lane[1], 4'b0000};
                lane_data = cur_word >> shamt;
                load_data = {{(DWIDTH-16){~uns_q & lane_data[15]}}, lane_data[15:0]};
                wr_mask   = DWIDTH'(16'hFFFF) << shamt;
                wr_data   = DWIDTH'(wdata_q[15:0]) << shamt;
            end
            default: begin
                // Word, and the reserved size treated as word; extension does not apply.
                load_data = cur_word;
                wr_mask   = '1;
                wr_data   = wdata_q;
            end
        endcase
        new_word = (cur_word & ~wr_mask) | (wr_data & wr_mask);
    end

    // Storage array: written only on the commit edge of an accepted, non-rejected store.
    // NOTE: the array has no reset so contents survive reset and it can map to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= new_word;
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    // A LATENCY of 1 loads the counter with 0 and spends one cycle in WAIT, so the
    // response always appears LATENCY edges after the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        size_q      <= bus.req_size;
                        uns_q       <= bus.req_unsigned;
                        err_q       <= req_err;
                        cnt         <= 4'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        rdata_q      <= (we_q || err_q) ? '0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder -- directed scenarios plus randomized traffic checked
// against a byte-addressed little-endian memory model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if #(.DWIDTH(32)) bus ();

    data_mem_responder #(.DWIDTH(32), .DEPTH(1024), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory: 1024 words = 4096 bytes, little endian.
    logic [7:0] mbytes [0:4095];

    function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [1:0] sz, input logic uns,
                                  output logic [31:0] rd, output logic err);
        int n;
        int base;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = 1'b0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        err = (sz == 2'd3) || (a % n != 0);
`endif
        base = int'(a[11:0]) / n * n;
        rd   = 32'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) mbytes[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[base + i];
            if (n < 4 && !uns && v[8*n-1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    // One complete transaction; reports data, error, accept-to-valid latency and
    // whether the stall/handshake behaviour held (stable response, back to IDLE).
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input int stall, input bit poke,
                          output logic [31:0] rd, output logic err, output int lat, output bit hs_ok);
        int w;
        hs_ok = 1'b1;
        w = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) hs_ok = 1'b0;
        bus.req_we       = we;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        rd  = bus.resp_rdata;
        err = bus.resp_err;
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_wdata = 32'hFFFF_FFFF;
            end
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd || bus.resp_err !== err ||
                bus.req_ready !== 1'b0) hs_ok = 1'b0;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) hs_ok = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    bit          ok;

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", bus.resp_valid); end
        n_cmp++;
        if (bus.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", bus.resp_rdata); end
        n_cmp++;
        if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", bus.resp_err); end
        n_cmp++;
        reset = 1'b0;
        @(negedge clk);
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
        n_cmp++;
    endtask

    task automatic test_word();
        access(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (lat !== 2) begin n_bad++; $display("FAIL word_store_lat got=%0d want=2", lat); end
        n_cmp++;
        if (rd !== 32'd0) begin n_bad++; $display("FAIL word_store_rdata got=%h want=0", rd); end
        n_cmp++;
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_load got=%h want=deadbeef", rd); end
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL word_load_lat got=%0d want=2", lat); end
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL word_handshake got=%b want=1", ok); end
        n_cmp++;
    endtask

    task automatic test_byte();
        access(1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0, 0, 1'b0, rd, err, lat, ok);
        access(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL byte_signed got=%h want=ffffff80", rd); end
        n_cmp++;
        access(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h00000080) begin n_bad++; $display("FAIL byte_unsigned got=%h want=00000080", rd); end
        n_cmp++;
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h80ADBEEF) begin n_bad++; $display("FAIL byte_merge got=%h want=80adbeef", rd); end
        n_cmp++;
    endtask

    task automatic test_half();
        access(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        access(1'b1, 32'h22, 32'hAAAA1234, 2'b01, 1'b0, 0, 1'b0, rd, err, lat, ok);
        access(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h00001234) begin n_bad++; $display("FAIL half_signed got=%h want=00001234", rd); end
        n_cmp++;
        access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h1234F00D) begin n_bad++; $display("FAIL half_merge got=%h want=1234f00d", rd); end
        n_cmp++;
    endtask

    task automatic test_stall();
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, 1'b1, rd, err, lat, ok);
        if (rd !== 32'h80ADBEEF) begin n_bad++; $display("FAIL stall_rdata got=%h want=80adbeef", rd); end
        n_cmp++;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_stable got=%b want=1", ok); end
        n_cmp++;
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h80ADBEEF) begin n_bad++; $display("FAIL stall_ignored_req got=%h want=80adbeef", rd); end
        n_cmp++;
    endtask

    task automatic test_reset_abort();
        access(1'b1, 32'h40, 32'h11223344, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = 32'h55;
        bus.req_size = 2'b10; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got=%b want=0", bus.resp_valid); end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b want=1", bus.req_ready); end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h11223344) begin n_bad++; $display("FAIL abort_mem got=%h want=11223344", rd); end
        n_cmp++;
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h80ADBEEF) begin n_bad++; $display("FAIL reset_keeps_mem got=%h want=80adbeef", rd); end
        n_cmp++;
    endtask

    task automatic test_misalign();
        access(1'b1, 32'h00, 32'hA5A50001, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        access(1'b0, 32'h02, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        if (err !== 1'b1) begin n_bad++; $display("FAIL misalign_err got=%b want=1", err); end
        n_cmp++;
        if (rd !== 32'd0) begin n_bad++; $display("FAIL misalign_rdata got=%h want=0", rd); end
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL misalign_lat got=%0d want=2", lat); end
        n_cmp++;
        access(1'b1, 32'h01, 32'hFFFFFFFF, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        access(1'b0, 32'h00, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'hA5A50001) begin n_bad++; $display("FAIL misalign_nowrite got=%h want=a5a50001", rd); end
        n_cmp++;
`else
        if (err !== 1'b0) begin n_bad++; $display("FAIL misalign_err got=%b want=0", err); end
        n_cmp++;
        if (rd !== 32'hA5A50001) begin n_bad++; $display("FAIL misalign_word got=%h want=a5a50001", rd); end
        n_cmp++;
        access(1'b0, 32'h00, 32'h0, 2'b11, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'hA5A50001) begin n_bad++; $display("FAIL size11_word got=%h want=a5a50001", rd); end
        n_cmp++;
        access(1'b0, 32'h01, 32'h0, 2'b01, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h00000001) begin n_bad++; $display("FAIL misalign_half got=%h want=00000001", rd); end
        n_cmp++;
`endif
    endtask

    task automatic test_wrap();
        access(1'b1, 32'h1050, 32'h0BADCAFE, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        access(1'b0, 32'h0050, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        if (rd !== 32'h0BADCAFE) begin n_bad++; $display("FAIL addr_wrap got=%h want=0badcafe", rd); end
        n_cmp++;
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] exp_rd;
        logic        exp_err;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            a  = 32'h100 + 32'(4 * i);
            model(1'b1, a, wd, 2'b10, 1'b0, exp_rd, exp_err);
            access(1'b1, a, wd, 2'b10, 1'b0, 0, 1'b0, rd, err, lat, ok);
        end
        for (int i = 0; i < 150; i++) begin
            we  = 1'($urandom_range(0, 1));
            a   = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 12);
            wd  = $urandom;
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            model(we, a, wd, sz, uns, exp_rd, exp_err);
            access(we, a, wd, sz, uns, $urandom_range(0, 2), 1'b0, rd, err, lat, ok);
            if (rd !== exp_rd) begin
                n_bad++;
                $display("FAIL rand_rdata op=%0d we=%b addr=%h size=%0d uns=%b got=%h want=%h",
                         i, we, a, sz, uns, rd, exp_rd);
            end
            n_cmp++;
            if (err !== exp_err) begin n_bad++; $display("FAIL rand_err op=%0d got=%b want=%b", i, err, exp_err); end
            n_cmp++;
            if (lat !== 2) begin n_bad++; $display("FAIL rand_lat op=%0d got=%0d want=2", i, lat); end
            n_cmp++;
            if (ok !== 1'b1) begin n_bad++; $display("FAIL rand_handshake op=%0d got=%b want=1", i, ok); end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_stall();
        test_reset_abort();
        test_misalign();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end
endmodule
